// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: load-use stall, multi-cycle MUL hold,
// branch flush and rs/rt forwarding. Optional perf counters under `HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_branch_tk,
    input  logic              exe_lw,
    input  logic              exe_mul,
    input  logic              exe_rf_wena,
    input  logic [REG_AW-1:0] exe_rf_waddr,
    input  logic              mem_rf_wena,
    input  logic [REG_AW-1:0] mem_rf_waddr,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              de_bubble,
    output logic              de_hold,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              mul_busy,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_flushes
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MUL_WAIT = 1'b1;

    localparam bit          MUL_EN     = (MUL_LAT > 1);
    localparam int unsigned CNT_INIT_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic mul_start;
    logic mul_hold;
    logic lu_hit;
    logic lu_stall;
    logic stall;
    logic flush;

    // A load result is not ready in EXE, so only non-load EXE writers forward.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] a,
        input logic              e_wena,
        input logic              e_lw,
        input logic [REG_AW-1:0] e_waddr,
        input logic              m_wena,
        input logic [REG_AW-1:0] m_waddr
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (a != '0) begin
            if (e_wena && !e_lw && (a == e_waddr))
                sel = FWD_EXE;
            else if (m_wena && (a == m_waddr))
                sel = FWD_MEM;
        end
        return sel;
    endfunction

    always_comb begin
        mul_start = MUL_EN && (state_q == RUN) && exe_mul;
        mul_hold  = mul_start || ((state_q == MUL_WAIT) && (cnt_q != 4'd0));
    end

    always_comb begin
        lu_hit = exe_lw && exe_rf_wena && (exe_rf_waddr != '0) && id_valid &&
                 ((id_rs_used && (id_rs_addr == exe_rf_waddr)) ||
                  (id_rt_used && (id_rt_addr == exe_rf_waddr)));
        // MUL hold outranks the load-use bubble; the bubble only fires in RUN.
        lu_stall = lu_hit && (state_q == RUN) && !mul_start;
        stall    = mul_hold || lu_stall;
        flush    = id_branch_tk && !stall;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mul_start) begin
                    state_d = MUL_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            MUL_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything is forced low while reset is asserted, including mid-MUL.
    assign pc_stall   = !rst && stall;
    assign ifid_stall = !rst && stall;
    assign ifid_flush = !rst && flush;
    assign de_bubble  = !rst && lu_stall;
    assign de_hold    = !rst && mul_hold;
    assign mul_busy   = !rst && (state_q == MUL_WAIT);

    assign fwd_rs_sel = rst ? FWD_RF : fwd_sel(id_rs_addr, exe_rf_wena, exe_lw, exe_rf_waddr,
                                               mem_rf_wena, mem_rf_waddr);
    assign fwd_rt_sel = rst ? FWD_RF : fwd_sel(id_rt_addr, exe_rf_wena, exe_lw, exe_rf_waddr,
                                               mem_rf_wena, mem_rf_waddr);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_stalls_d  = perf_stalls_q + {31'd0, pc_stall};
        perf_flushes_d = perf_flushes_q + {31'd0, ifid_flush};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stalls_q  <= 32'd0;
            perf_flushes_q <= 32'd0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`else
    assign perf_stalls  = 32'd0;
    assign perf_flushes = 32'd0;
`endif

endmodule
